// File: rtl/ssd_scan_controller_if.sv
// ssd_scan_controller_if
// Bundles the data/strobe inputs and display outputs of ssd_scan_controller.
// Signals:
//   value_in   16  hex value, nibble k belongs to digit k
//   dp_in      4   decimal point per digit, captured with value_in
//   load       1   one-cycle capture strobe
//   pending    1   a captured value is waiting for the next frame boundary
//   digit_sel  2   current digit index {S1,S0} for the anode decoder
//   an         4   anode enables
//   seg        7   segments {g,f,e,d,c,b,a}
//   dp         1   decimal point of the current digit
//   frame_tick 1   pulse on the last cycle of the digit-3 slot
// Modports: master drives value_in/dp_in/load, slave is the controller.
interface ssd_scan_controller_if;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        pending;
  logic [1:0]  digit_sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  modport master (
    output value_in, dp_in, load,
    input  pending, digit_sel, an, seg, dp, frame_tick
  );

  modport slave (
    input  value_in, dp_in, load,
    output pending, digit_sel, an, seg, dp, frame_tick
  );
endinterface

// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller
// Time-multiplexed driver for a 4-digit seven-segment display. Each digit slot
// is TICKS_PER_DIGIT cycles: BLANK_TICKS cycles with every anode off (to avoid
// ghosting) followed by the SHOW cycles. The displayed value is double-buffered
// so that a new value only takes effect at a frame boundary (last cycle of the
// digit-3 slot).
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  ssd_scan_controller_if.slave (value_in, dp_in, load in;
//        pending, digit_sel, an, seg, dp, frame_tick out)
// Parameters:
//   TICKS_PER_DIGIT  cycles per digit slot (>= 2)
//   BLANK_TICKS      blank cycles per slot (1 .. TICKS_PER_DIGIT-1)
//   ACTIVE_LOW       1: an/seg/dp active-low, 0: active-high
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                          nonzero nibble are suppressed (digit 0 always shown).
module ssd_scan_controller #(
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int BLANK_TICKS     = 500,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ssd_scan_controller_if.slave  bus
);

  localparam int CW = (TICKS_PER_DIGIT > 2) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [CW-1:0] LAST_TICK  = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_TICKS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic [1:0]    digit;
  logic          slot_end;
  logic          boundary;

  logic [15:0]   shown_value;
  logic [3:0]    shown_dp;
  logic [15:0]   buf_value;
  logic [3:0]    buf_dp;
  logic          pending_q;

  logic          digit_on;
  logic [3:0]    nibble;
  logic [3:0]    an_raw;
  logic [6:0]    seg_raw;
  logic          dp_raw;

  // Active-high gfedcba pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // The SHOW phase always ends on the last tick of a slot, so the frame
  // boundary is simply the last tick of the digit-3 slot.
  assign slot_end = (count == LAST_TICK);
  assign boundary = (state == SHOW) && (digit == 2'd3) && slot_end;

  // State register together with the slot counter and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK;
      count <= '0;
      digit <= 2'd0;
    end else begin
      state <= state_next;
      count <= slot_end ? '0 : count + 1'b1;
      if (slot_end) begin
        digit <= digit + 2'd1;
      end
    end
  end

  // Next-state logic: BLANK for the first BLANK_TICKS cycles of a slot.
  always_comb begin
    state_next = state;
    case (state)
      BLANK:   if (count == LAST_BLANK) state_next = SHOW;
      SHOW:    if (slot_end)            state_next = BLANK;
      default: state_next = BLANK;
    endcase
  end

  // Double buffer. A load on the boundary cycle bypasses the buffer so the
  // newest value is never lost or delayed by a whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shown_value <= 16'h0000;
      shown_dp    <= 4'b0000;
      buf_value   <= 16'h0000;
      buf_dp      <= 4'b0000;
      pending_q   <= 1'b0;
    end else if (boundary) begin
      pending_q <= 1'b0;
      if (bus.load) begin
        shown_value <= bus.value_in;
        shown_dp    <= bus.dp_in;
      end else if (pending_q) begin
        shown_value <= buf_value;
        shown_dp    <= buf_dp;
      end
    end else if (bus.load) begin
      buf_value <= bus.value_in;
      buf_dp    <= bus.dp_in;
      pending_q <= 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [1:0] top_digit;

  // Index of the most significant nonzero nibble; 0 when the value is zero,
  // which keeps digit 0 visible.
  always_comb begin
    top_digit = 2'd0;
    if (shown_value[15:12] != 4'h0)     top_digit = 2'd3;
    else if (shown_value[11:8] != 4'h0) top_digit = 2'd2;
    else if (shown_value[7:4] != 4'h0)  top_digit = 2'd1;
  end

  assign digit_on = (digit <= top_digit);
`else
  assign digit_on = 1'b1;
`endif

  assign nibble = shown_value[{digit, 2'b00} +: 4];

  // Output decode from registered state only.
  always_comb begin
    an_raw  = 4'b0000;
    seg_raw = 7'b0000000;
    dp_raw  = 1'b0;
    if ((state == SHOW) && digit_on) begin
      an_raw  = 4'b0001 << digit;
      seg_raw = hex_to_seg(nibble);
      dp_raw  = shown_dp[digit];
    end
  end

  assign bus.an         = (ACTIVE_LOW != 0) ? ~an_raw  : an_raw;
  assign bus.seg        = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
  assign bus.dp         = (ACTIVE_LOW != 0) ? ~dp_raw  : dp_raw;
  assign bus.digit_sel  = digit;
  assign bus.pending    = pending_q;
  assign bus.frame_tick = boundary;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// tb_ssd_scan_controller
// Directed scoreboard bench for ssd_scan_controller with TICKS_PER_DIGIT=8,
// BLANK_TICKS=2. Expected values are queued with the cycle they apply to and
// popped when that cycle is sampled. A second instance with ACTIVE_LOW=1
// shares the inputs to cover the output inversion.
// Build option: LEADING_ZERO_BLANK_EN selects the suppressed-digit expectations.
module tb_ssd_scan_controller;

  typedef enum int {SIG_AN, SIG_SEG, SIG_DP, SIG_SEL, SIG_PEND, SIG_FT,
                    SIG_AN_L, SIG_SEG_L, SIG_DP_L} sig_e;

  typedef struct {
    string       tag;
    int          cyc;
    sig_e        sig;
    logic [15:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ssd_scan_controller_if bus ();
  ssd_scan_controller_if bus_low ();

  ssd_scan_controller #(.TICKS_PER_DIGIT(8), .BLANK_TICKS(2), .ACTIVE_LOW(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  ssd_scan_controller #(.TICKS_PER_DIGIT(8), .BLANK_TICKS(2), .ACTIVE_LOW(1)) dut_low (
    .clk (clk),
    .rst (rst),
    .bus (bus_low.slave)
  );

  assign bus_low.value_in = bus.value_in;
  assign bus_low.dp_in    = bus.dp_in;
  assign bus_low.load     = bus.load;

  always #5 clk = ~clk;

  exp_t sb[$];
  int   cyc = -1;
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [15:0] observe(sig_e s);
    case (s)
      SIG_AN:    return {12'h000, bus.an};
      SIG_SEG:   return {9'h000, bus.seg};
      SIG_DP:    return {15'h0000, bus.dp};
      SIG_SEL:   return {14'h0000, bus.digit_sel};
      SIG_PEND:  return {15'h0000, bus.pending};
      SIG_FT:    return {15'h0000, bus.frame_tick};
      SIG_AN_L:  return {12'h000, bus_low.an};
      SIG_SEG_L: return {9'h000, bus_low.seg};
      default:   return {15'h0000, bus_low.dp};
    endcase
  endfunction

  task automatic pushExp(input string tag, input int c, input sig_e s, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  // Compare and retire every queued expectation that belongs to this cycle.
  task automatic checkOutput();
    logic [15:0] obs;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        obs = observe(sb[i].sig);
        vectors++;
        assert (obs === sb[i].val) else begin
          miscompares++;
          $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", sb[i].tag, cyc, obs, sb[i].val);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #2;
    cyc++;
    checkOutput();
  endtask

  task automatic runTo(input int target);
    while (cyc < target) stepCycle();
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d);
    bus.value_in = v;
    bus.dp_in    = d;
    bus.load     = 1'b1;
    @(posedge clk);
    #2;
    bus.load = 1'b0;
    cyc++;
    checkOutput();
  endtask

  // Three reset cycles; leaves the bench at cycle 0 (first cycle after rst falls).
  task automatic applyReset();
    rst      = 1'b1;
    bus.load = 1'b0;
    @(posedge clk);
    #2;
    cyc = -1;
    checkOutput();
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic flushLeftovers(input string scen);
    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("[TB] FAIL %s leftover expectations observed=%0d expected=0", scen, sb.size());
    end
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.value_in = 16'h0000;
    bus.dp_in    = 4'b0000;
    bus.load     = 1'b0;

    // Scenario 1: reset values and first slot timing.
    pushExp("rst_an", -1, SIG_AN, 16'h0);
    pushExp("rst_seg", -1, SIG_SEG, 16'h0);
    pushExp("rst_sel", -1, SIG_SEL, 16'h0);
    pushExp("rst_pend", -1, SIG_PEND, 16'h0);
    pushExp("rst_ft", -1, SIG_FT, 16'h0);
    pushExp("rst_an_low", -1, SIG_AN_L, 16'hF);
    pushExp("rst_seg_low", -1, SIG_SEG_L, 16'h7F);
    pushExp("rst_dp_low", -1, SIG_DP_L, 16'h1);
    for (int c = 0; c < 2; c++) pushExp("s1_blank_an", c, SIG_AN, 16'h0);
    for (int c = 2; c < 8; c++) begin
      pushExp("s1_show_an", c, SIG_AN, 16'h1);
      pushExp("s1_show_seg", c, SIG_SEG, 16'h3F);
    end
    pushExp("s1_an_low", 2, SIG_AN_L, 16'hE);
    pushExp("s1_seg_low", 2, SIG_SEG_L, 16'h40);
    pushExp("s1_sel", 8, SIG_SEL, 16'h1);
    pushExp("s1_an8", 8, SIG_AN, 16'h0);
    applyReset();
    checkOutput();
    runTo(8);
    flushLeftovers("s1");

    // Scenario 2: load mid-frame lands on the next frame.
    applyReset();
    pushExp("s2_pend5", 5, SIG_PEND, 16'h0);
    pushExp("s2_pend6", 6, SIG_PEND, 16'h1);
    pushExp("s2_pend31", 31, SIG_PEND, 16'h1);
    pushExp("s2_pend32", 32, SIG_PEND, 16'h0);
    for (int d = 0; d < 4; d++) pushExp("s2_old_seg", 8 * d + 4, SIG_SEG, 16'h3F);
    for (int c = 0; c < 64; c++) pushExp("s2_ft", c, SIG_FT, (c == 31 || c == 63) ? 16'h1 : 16'h0);
    pushExp("s2_blank_an", 33, SIG_AN, 16'h0);
    for (int c = 34; c < 40; c++) begin
      pushExp("s2_d0_seg", c, SIG_SEG, 16'h71);
      pushExp("s2_d0_dp", c, SIG_DP, 16'h1);
    end
    pushExp("s2_d0_an", 36, SIG_AN, 16'h1);
    for (int c = 42; c < 48; c++) pushExp("s2_d1_seg", c, SIG_SEG, 16'h77);
    pushExp("s2_d1_dp", 44, SIG_DP, 16'h0);
    pushExp("s2_d2_seg", 52, SIG_SEG, 16'h5B);
    pushExp("s2_d2_an", 52, SIG_AN, 16'h4);
    pushExp("s2_d3_seg", 60, SIG_SEG, 16'h06);
    pushExp("s2_d3_an", 60, SIG_AN, 16'h8);
    checkOutput();
    runTo(5);
    applyStimulus(16'h12AF, 4'b0001);
    runTo(63);
    flushLeftovers("s2");

    // Scenario 3: the last of several mid-frame loads wins.
    applyReset();
    for (int c = 0; c < 64; c++) begin
      if ((c % 8) >= 2) pushExp("s3_seg", c, SIG_SEG, (c < 32) ? 16'h3F : 16'h66);
      else              pushExp("s3_blank_an", c, SIG_AN, 16'h0);
    end
    pushExp("s3_pend11", 11, SIG_PEND, 16'h1);
    pushExp("s3_pend32", 32, SIG_PEND, 16'h0);
    checkOutput();
    runTo(10);
    applyStimulus(16'h3333, 4'b0000);
    runTo(20);
    applyStimulus(16'h4444, 4'b0000);
    runTo(63);
    flushLeftovers("s3");

    // Scenario 4: load on the boundary cycle goes straight to the display.
    applyReset();
    pushExp("s4_ft31", 31, SIG_FT, 16'h1);
    pushExp("s4_pend31", 31, SIG_PEND, 16'h0);
    pushExp("s4_pend32", 32, SIG_PEND, 16'h0);
    pushExp("s4_pend33", 33, SIG_PEND, 16'h0);
    for (int c = 34; c < 40; c++) pushExp("s4_d0_seg", c, SIG_SEG, 16'h6D);
    pushExp("s4_d1_seg", 44, SIG_SEG, 16'h3F);
    checkOutput();
    runTo(31);
    applyStimulus(16'h0005, 4'b0000);
    runTo(47);
    flushLeftovers("s4");

    // Scenario 5: reset mid-slot discards the pending value.
    applyReset();
    pushExp("s5_pend6", 6, SIG_PEND, 16'h1);
    pushExp("s5_pend12", 12, SIG_PEND, 16'h1);
    pushExp("s5_sel12", 12, SIG_SEL, 16'h1);
    pushExp("s5_an12", 12, SIG_AN, 16'h2);
    checkOutput();
    runTo(5);
    applyStimulus(16'hBEEF, 4'b1111);
    runTo(12);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    cyc = 0;
    pushExp("s5_post_an", 0, SIG_AN, 16'h0);
    pushExp("s5_post_sel", 0, SIG_SEL, 16'h0);
    pushExp("s5_post_pend", 0, SIG_PEND, 16'h0);
    for (int d = 0; d < 8; d++) pushExp("s5_zero_seg", 8 * d + 4, SIG_SEG, 16'h3F);
    pushExp("s5_dp36", 36, SIG_DP, 16'h0);
    pushExp("s5_pend40", 40, SIG_PEND, 16'h0);
    checkOutput();
    runTo(63);
    flushLeftovers("s5");

    // Scenario 6: value 0x0030 with leading-zero handling per build option.
    applyReset();
    pushExp("s6_d0_an", 36, SIG_AN, 16'h1);
    pushExp("s6_d0_seg", 36, SIG_SEG, 16'h3F);
    pushExp("s6_d0_dp", 36, SIG_DP, 16'h1);
    pushExp("s6_d1_an", 44, SIG_AN, 16'h2);
    pushExp("s6_d1_seg", 44, SIG_SEG, 16'h4F);
    pushExp("s6_d1_dp", 44, SIG_DP, 16'h1);
    pushExp("s6_ft55", 55, SIG_FT, 16'h0);
    pushExp("s6_ft63", 63, SIG_FT, 16'h1);
    pushExp("s6_ft95", 95, SIG_FT, 16'h1);
    pushExp("s6_sel52", 52, SIG_SEL, 16'h2);
`ifdef LEADING_ZERO_BLANK_EN
    for (int c = 48; c < 64; c++) pushExp("s6_lz_an", c, SIG_AN, 16'h0);
    pushExp("s6_lz_dp2", 52, SIG_DP, 16'h0);
    pushExp("s6_lz_dp3", 60, SIG_DP, 16'h0);
    pushExp("s6_lz_an84", 84, SIG_AN, 16'h0);
`else
    pushExp("s6_d2_an", 52, SIG_AN, 16'h4);
    pushExp("s6_d2_seg", 52, SIG_SEG, 16'h3F);
    pushExp("s6_d2_dp", 52, SIG_DP, 16'h1);
    pushExp("s6_d3_an", 60, SIG_AN, 16'h8);
    pushExp("s6_d3_seg", 60, SIG_SEG, 16'h3F);
`endif
    checkOutput();
    runTo(31);
    applyStimulus(16'h0030, 4'b1111);
    runTo(95);
    flushLeftovers("s6");

    // Scenario 7: walk all sixteen hex glyphs over four frames.
    applyReset();
    for (int f = 1; f <= 4; f++) begin
      for (int d = 0; d < 4; d++) begin
        pushExp($sformatf("s7_seg_%0d", 4 * (f - 1) + d), 32 * f + 8 * d + 4, SIG_SEG,
                16'(hex_tab[4 * (f - 1) + d]));
        pushExp("s7_an", 32 * f + 8 * d + 4, SIG_AN, 16'(4'b0001 << d));
      end
    end
    for (int d = 0; d < 4; d++) pushExp("s7_dp", 32 + 8 * d + 4, SIG_DP, (d % 2 == 1) ? 16'h1 : 16'h0);
    checkOutput();
    runTo(5);
    applyStimulus(16'h3210, 4'b1010);
    runTo(40);
    applyStimulus(16'h7654, 4'b0000);
    runTo(70);
    applyStimulus(16'hBA98, 4'b0000);
    runTo(100);
    applyStimulus(16'hFEDC, 4'b0000);
    runTo(159);
    flushLeftovers("s7");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
